// File: rtl/synth_pkg.sv
// Shared MIDI constants for the synth voice path.
package synth_pkg;
  localparam int MIDI_NOTES = 128;
  localparam int VEL_W      = 7;
  localparam int NOTE_NUM_W = 7;
endpackage

// File: rtl/midi_key_map_if.sv
// Note-event bus into midi_key_map and the key-state outputs it drives.
interface midi_key_map_if #(
  parameter int LINES = synth_pkg::MIDI_NOTES
);
  logic                             note_stb;
  logic                             note_on;
  logic [synth_pkg::NOTE_NUM_W-1:0] note_num;
  logic [synth_pkg::VEL_W-1:0]      note_vel;
  logic                             all_off;
  logic                             sus_in;
  logic [LINES-1:0]                 keys;
  logic [LINES-1:0]                 top_onehot;
  logic                             gate;
  logic                             retrig;

  modport master (
    output note_stb, note_on, note_num, note_vel, all_off, sus_in,
    input  keys, top_onehot, gate, retrig
  );

  modport slave (
    input  note_stb, note_on, note_num, note_vel, all_off, sus_in,
    output keys, top_onehot, gate, retrig
  );
endinterface

// File: rtl/midi_key_map_top_bit_isolate.sv
// Combinational highest-set-bit isolation: y = x & ~(OR of all higher bits of x).
module top_bit_isolate #(
  parameter int LINES = 128
) (
  input  logic [LINES-1:0] x,
  output logic [LINES-1:0] y
);
  logic [LINES-1:0] higher_s;

  // Smear set bits downward so higher_s[i] is set when any bit above i is set
  always_comb begin
    higher_s[LINES-1] = 1'b0;
    for (int i = LINES - 2; i >= 0; i--) begin
      higher_s[i] = higher_s[i+1] | x[i+1];
    end
  end

  assign y = x & ~higher_s;
endmodule

// File: rtl/midi_key_map.sv
// Key bitmap and highest-key tracker for the monophonic voice path.
// Optional feature: define SUSTAIN_EN to enable sustain-pedal handling via sus_in.
module midi_key_map
  import synth_pkg::*;
#(
  parameter int LINES  = MIDI_NOTES,
  parameter int NOTE_W = $clog2(LINES)
) (
  input  logic           clk,
  input  logic           rst_n,
  midi_key_map_if.slave  bus
);
  localparam int IDX_W = (NOTE_W > NOTE_NUM_W) ? NOTE_W : NOTE_NUM_W;

  logic [LINES-1:0] note_mask_s;
  logic [LINES-1:0] held_r;
  logic [LINES-1:0] held_nxt_s;
  logic [LINES-1:0] sus_nxt_s;
  logic [LINES-1:0] keys_r;
  logic [LINES-1:0] iso_s;
  logic [LINES-1:0] top_r;
  logic             gate_r;
  logic             retrig_r;
  logic             note_on_s;
`ifdef SUSTAIN_EN
  logic [LINES-1:0] sus_r;
  logic             pedal_r;
  logic             pedal_d_r;
`endif

  // Note numbers at or above LINES decode to an empty mask, so they change nothing
  always_comb begin
    for (int i = 0; i < LINES; i++) begin
      note_mask_s[i] = (IDX_W'(bus.note_num) == IDX_W'(i));
    end
  end

  assign note_on_s = bus.note_on & (bus.note_vel != {VEL_W{1'b0}});

  // Next held/sustained state; all_off drops any same-cycle note event
  always_comb begin
    held_nxt_s = held_r;
`ifdef SUSTAIN_EN
    sus_nxt_s  = sus_r;
`else
    sus_nxt_s  = {LINES{1'b0}};
`endif
    if (bus.all_off) begin
      held_nxt_s = {LINES{1'b0}};
      sus_nxt_s  = {LINES{1'b0}};
    end else begin
`ifdef SUSTAIN_EN
      if (pedal_d_r & ~pedal_r) begin
        sus_nxt_s = {LINES{1'b0}};
      end else begin
        sus_nxt_s = sus_r;
      end
`endif
      if (bus.note_stb) begin
        if (note_on_s) begin
          held_nxt_s = held_r | note_mask_s;
          sus_nxt_s  = sus_nxt_s & ~note_mask_s;
        end else begin
`ifdef SUSTAIN_EN
          // Only keys actually held move into sustain
          if (pedal_r) begin
            sus_nxt_s = sus_nxt_s | (note_mask_s & held_r);
          end else begin
            sus_nxt_s = sus_nxt_s;
          end
`endif
          held_nxt_s = held_r & ~note_mask_s;
        end
      end else begin
        held_nxt_s = held_r;
      end
    end
  end

  // Key state registers, plus the registered pedal and its previous value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_r    <= {LINES{1'b0}};
      keys_r    <= {LINES{1'b0}};
`ifdef SUSTAIN_EN
      sus_r     <= {LINES{1'b0}};
      pedal_r   <= 1'b0;
      pedal_d_r <= 1'b0;
`endif
    end else begin
      held_r    <= held_nxt_s;
      keys_r    <= held_nxt_s | sus_nxt_s;
`ifdef SUSTAIN_EN
      sus_r     <= sus_nxt_s;
      pedal_r   <= bus.sus_in;
      pedal_d_r <= pedal_r;
`endif
    end
  end

  top_bit_isolate #(.LINES(LINES)) u_top_bit_isolate (
    .x (keys_r),
    .y (iso_s)
  );

  // top_onehot, gate and retrig all register from the same keys_r snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_r    <= {LINES{1'b0}};
      gate_r   <= 1'b0;
      retrig_r <= 1'b0;
    end else begin
      top_r    <= iso_s;
      gate_r   <= |keys_r;
      retrig_r <= (|iso_s) & (iso_s != top_r);
    end
  end

  assign bus.keys       = keys_r;
  assign bus.top_onehot = top_r;
  assign bus.gate       = gate_r;
  assign bus.retrig     = retrig_r;
endmodule

// File: tb/tb_midi_key_map.sv
// Randomized bench for midi_key_map (LINES=128 and LINES=64) against a per-note reference model.
module tb_midi_key_map;
  logic       clk;
  logic       rst_n;
  logic       note_stb;
  logic       note_on;
  logic [6:0] note_num;
  logic [6:0] note_vel;
  logic       all_off;
  logic       sus_in;

  int checks;
  int errors;

  midi_key_map_if #(.LINES(128)) bus128 ();
  midi_key_map_if #(.LINES(64))  bus64 ();

  assign bus128.note_stb = note_stb;
  assign bus128.note_on  = note_on;
  assign bus128.note_num = note_num;
  assign bus128.note_vel = note_vel;
  assign bus128.all_off  = all_off;
  assign bus128.sus_in   = sus_in;
  assign bus64.note_stb  = note_stb;
  assign bus64.note_on   = note_on;
  assign bus64.note_num  = note_num;
  assign bus64.note_vel  = note_vel;
  assign bus64.all_off   = all_off;
  assign bus64.sus_in    = sus_in;

  midi_key_map #(.LINES(128)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus128));
  midi_key_map #(.LINES(64))  u_dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-note held/sustained flags plus the output pipeline stage
  bit          held_m [128];
  bit          sus_m  [128];
  logic [127:0] keys_m, top_m, top64_m;
  logic        gate_m, retrig_m, gate64_m, retrig64_m;
  bit          ped_m, ped_d_m;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] highest(input logic [127:0] k);
    logic [127:0] r;
    r = 128'd0;
    for (int i = 127; i >= 0; i--) begin
      if (k[i]) begin
        r[i] = 1'b1;
        break;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) begin
      held_m[i] = 1'b0;
      sus_m[i]  = 1'b0;
    end
    keys_m = 128'd0; top_m = 128'd0; top64_m = 128'd0;
    gate_m = 1'b0; retrig_m = 1'b0; gate64_m = 1'b0; retrig64_m = 1'b0;
    ped_m = 1'b0; ped_d_m = 1'b0;
  endtask

  task automatic model_edge();
    logic [127:0] nt;
    logic [127:0] k64;
    int n;
    bit on;
    nt = highest(keys_m);
    retrig_m = (nt != 128'd0) && (nt != top_m);
    top_m = nt;
    gate_m = (keys_m != 128'd0);
    k64 = {64'd0, keys_m[63:0]};
    nt = highest(k64);
    retrig64_m = (nt != 128'd0) && (nt != top64_m);
    top64_m = nt;
    gate64_m = (k64 != 128'd0);
    if (all_off) begin
      for (int i = 0; i < 128; i++) begin
        held_m[i] = 1'b0;
        sus_m[i]  = 1'b0;
      end
    end else begin
`ifdef SUSTAIN_EN
      if (ped_d_m && !ped_m) begin
        for (int i = 0; i < 128; i++) sus_m[i] = 1'b0;
      end
`endif
      if (note_stb) begin
        n = int'(note_num);
        on = note_on && (note_vel != 7'd0);
        if (on) begin
          held_m[n] = 1'b1;
          sus_m[n]  = 1'b0;
        end else if (held_m[n]) begin
          held_m[n] = 1'b0;
`ifdef SUSTAIN_EN
          if (ped_m) sus_m[n] = 1'b1;
`endif
        end
      end
    end
    for (int i = 0; i < 128; i++) keys_m[i] = held_m[i] | sus_m[i];
    ped_d_m = ped_m;
`ifdef SUSTAIN_EN
    ped_m = sus_in;
`endif
  endtask

  task automatic compare_all();
    check("keys", bus128.keys, keys_m);
    check("top", bus128.top_onehot, top_m);
    check("gate", 128'(bus128.gate), 128'(gate_m));
    check("retrig", 128'(bus128.retrig), 128'(retrig_m));
    check("onehot0", 128'($onehot0(bus128.top_onehot)), 128'd1);
    check("keys64", 128'(bus64.keys), {64'd0, keys_m[63:0]});
    check("top64", 128'(bus64.top_onehot), top64_m);
    check("gate64", 128'(bus64.gate), 128'(gate64_m));
    check("retrig64", 128'(bus64.retrig), 128'(retrig64_m));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    @(negedge clk);
    compare_all();
  endtask

  task automatic ev(input bit stb, input bit on, input int num, input int vel, input bit off);
    note_stb = stb;
    note_on  = on;
    note_num = 7'(num);
    note_vel = 7'(vel);
    all_off  = off;
    step();
    note_stb = 1'b0;
    all_off  = 1'b0;
  endtask

  task automatic async_reset();
    @(posedge clk);
    model_edge();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_keys", bus128.keys, 128'd0);
    check("rst_top", bus128.top_onehot, 128'd0);
    check("rst_gate", 128'(bus128.gate), 128'd0);
    check("rst_retrig", 128'(bus128.retrig), 128'd0);
    check("rst_keys64", 128'(bus64.keys), 128'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    note_stb = 1'b0; note_on = 1'b0; note_num = 7'd0; note_vel = 7'd0;
    all_off = 1'b0; sus_in = 1'b0;
    model_reset();
    #12;
    check("reset_keys", bus128.keys, 128'd0);
    check("reset_gate", 128'(bus128.gate), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single note: keys at N+1, top/gate/retrig at N+2, retrig one cycle only
    ev(1'b1, 1'b1, 60, 100, 1'b0);
    check("t1_key60", 128'(bus128.keys[60]), 128'd1);
    step();
    check("t1_retrig", 128'(bus128.retrig), 128'd1);
    step();
    check("t1_retrig_drop", 128'(bus128.retrig), 128'd0);

    // Higher note then release: 60->72->60, then silence with no retrig
    ev(1'b1, 1'b1, 72, 90, 1'b0);
    step();
    ev(1'b1, 1'b0, 72, 64, 1'b0);
    step();
    check("t2_fallback_retrig", 128'(bus128.retrig), 128'd1);
    ev(1'b1, 1'b0, 60, 64, 1'b0);
    step();
    check("t2_gate_off", 128'(bus128.gate), 128'd0);
    check("t2_no_retrig", 128'(bus128.retrig), 128'd0);

    // Velocity-0 note-on acts as note-off; repeated note-on gives no retrig
    ev(1'b1, 1'b1, 64, 80, 1'b0);
    step(); step();
    ev(1'b1, 1'b1, 64, 80, 1'b0);
    step();
    check("t3_repeat_no_retrig", 128'(bus128.retrig), 128'd0);
    ev(1'b1, 1'b1, 64, 0, 1'b0);
    check("t3_vel0_off", 128'(bus128.keys[64]), 128'd0);
    step(); step();

`ifdef SUSTAIN_EN
    sus_in = 1'b1;
    step(); step();
    ev(1'b1, 1'b1, 48, 70, 1'b0);
    ev(1'b1, 1'b0, 48, 0, 1'b0);
    step();
    check("t4_sustained", 128'(bus128.keys[48]), 128'd1);
    sus_in = 1'b0;
    step();
    step();
    check("t4_released", 128'(bus128.keys[48]), 128'd0);
    step(); step();
`endif

    // all_off beats a same-cycle note-on; note 127 ignored by the 64-line instance
    ev(1'b1, 1'b1, 30, 50, 1'b0);
    ev(1'b1, 1'b1, 90, 50, 1'b1);
    check("t5_alloff", bus128.keys, 128'd0);
    ev(1'b1, 1'b1, 127, 50, 1'b0);
    step(); step();
    check("t5_ignore64", 128'(bus64.gate), 128'd0);
    check("t5_accept128", 128'(bus128.gate), 128'd1);

    // Random back-to-back bursts with a mid-burst asynchronous reset
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        async_reset();
      end
      note_stb = ($urandom_range(0, 3) != 0);
      note_on  = ($urandom_range(0, 9) < 6);
      note_num = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                             : 7'($urandom_range(56, 67));
      note_vel = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      all_off  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) == 0) sus_in = ~sus_in;
      step();
    end
    note_stb = 1'b0;
    all_off  = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
